// File: rtl/sap_core_param.sv
// rtl/sap_core_param.sv - parametrised SAP core with program-load port, run control and flags
module sap_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] acc_dbg,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic              zero,
  output logic              carry
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'hE);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM, S_ALU, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, b_q, b_d, acc_q, acc_d, out_q, out_d;
  logic              zero_q, zero_d, carry_q, carry_d, out_valid_q, out_valid_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [OPC_W-1:0]  opc;
  logic [ADDR_W-1:0] opnd;
  logic [DATA_W-1:0] imm;
  logic [DATA_W:0]   sum_w, diff_w;

  assign opc    = ir_q[OPC_W+ADDR_W-1:ADDR_W];
  assign opnd   = ir_q[ADDR_W-1:0];
  assign imm    = {{(DATA_W-ADDR_W){1'b0}}, opnd};
  assign sum_w  = {1'b0, acc_q} + {1'b0, b_q};
  // Subtract as ACC + ~B + 1 so the carry-out reads as "no borrow".
  assign diff_w = {1'b0, acc_q} + {1'b0, ~b_q} + (DATA_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_d       = out_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = prog_addr;
    mem_wdata   = prog_data;
    case (state_q)
      S_IDLE, S_HALT: begin
        mem_we = prog_we;
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          acc_d   = '0;
          zero_d  = 1'b0;
          carry_d = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = mem_q[pc_q];
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (opc)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            mar_d   = opnd;
            state_d = S_MEM;
          end
          OP_LDI: begin
            acc_d  = imm;
            zero_d = (imm == '0);
          end
          OP_JMP: pc_d = opnd;
          OP_JC:  if (carry_q) pc_d = opnd;
          OP_JZ:  if (zero_q) pc_d = opnd;
          OP_OUT: begin
            out_d       = acc_q;
            out_valid_d = 1'b1;
          end
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEM: begin
        if (opc == OP_STA) begin
          mem_we    = 1'b1;
          mem_waddr = mar_q;
          mem_wdata = acc_q;
          state_d   = S_FETCH;
        end else begin
          b_d     = mem_q[mar_q];
          state_d = S_ALU;
        end
      end
      S_ALU: begin
        state_d = S_FETCH;
        case (opc)
          OP_ADD: begin
            acc_d   = sum_w[DATA_W-1:0];
            carry_d = sum_w[DATA_W];
            zero_d  = (sum_w[DATA_W-1:0] == '0);
          end
          OP_SUB: begin
            acc_d   = diff_w[DATA_W-1:0];
            carry_d = diff_w[DATA_W];
            zero_d  = (diff_w[DATA_W-1:0] == '0);
          end
          default: begin
            acc_d  = b_q;
            zero_d = (b_q == '0);
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  // RAM survives reset; a write pending on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_MEM) || (state_q == S_ALU);
  assign halted    = (state_q == S_HALT);
  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign acc_dbg   = acc_q;
  assign pc_dbg    = pc_q;
  assign zero      = zero_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_sap_core_param.sv
// tb/tb_sap_core_param.sv - scoreboard bench for sap_core_param
module tb_sap_core_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic       start = 1'b0;
  logic       busy, halted, out_valid, zero, carry;
  logic [7:0] out_data, acc_dbg;
  logic [3:0] pc_dbg;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];

  sap_core_param #(.DATA_W(8), .ADDR_W(4), .OPC_W(4)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .busy(busy), .halted(halted),
    .out_data(out_data), .out_valid(out_valid), .acc_dbg(acc_dbg),
    .pc_dbg(pc_dbg), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected output.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      pulses++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_valid_unexpected got=%0h expected=none", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL out_data got=%0h expected=%0h", out_data, e);
        end
      end
    end
  end

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) load(4'(i), 8'h80);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_prog(input int budget, input bit poke, output int cyc, output logic [3:0] pc0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pc0 = pc_dbg;
    cyc = 0;
    if (poke) begin
      prog_we = 1'b1; prog_addr = 4'hC; prog_data = 8'h55;
    end
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) prog_we = 1'b0;
    end
    prog_we = 1'b0;
  endtask

  initial begin
    int cyc;
    int p0;
    logic [3:0] pc0;
    logic [3:0] prev_pc;
    bit wrapped;

    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset after activity: LDI 5 then spin on JMP 0
    clear_mem();
    load(4'h0, 8'h45);
    load(4'h1, 8'h50);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("spin_acc", acc_dbg, 8'h05);
    do_reset(2);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_acc", acc_dbg, 0);
    check("rst_pc", pc_dbg, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_zero", zero, 0);
    check("rst_carry", carry, 0);

    // Add program: 5 + 3
    clear_mem();
    load(4'h0, 8'h09); load(4'h1, 8'h1A); load(4'h2, 8'hE0); load(4'h3, 8'hF0);
    load(4'h9, 8'h05); load(4'hA, 8'h03);
    exp_q.push_back(8'h08);
    p0 = pulses;
    run_prog(40, 0, cyc, pc0);
    check("add_halt_cycles", cyc, 12);
    check("add_halted", halted, 1);
    check("add_acc", acc_dbg, 8'h08);
    check("add_pulses", pulses - p0, 1);

    // Overflow with JC taken, skipping LDI 1
    clear_mem();
    load(4'h0, 8'h09); load(4'h1, 8'h1A); load(4'h2, 8'h66); load(4'h3, 8'h41);
    load(4'h4, 8'hE0); load(4'h5, 8'hF0); load(4'h6, 8'hE0); load(4'h7, 8'hF0);
    load(4'h9, 8'hFF); load(4'hA, 8'h01);
    exp_q.push_back(8'h00);
    p0 = pulses;
    run_prog(40, 0, cyc, pc0);
    check("jc_halt_cycles", cyc, 14);
    check("jc_acc", acc_dbg, 8'h00);
    check("jc_zero", zero, 1);
    check("jc_carry", carry, 1);
    check("jc_pc", pc_dbg, 4'h8);
    check("jc_pulses", pulses - p0, 1);

    // SUB with borrow, JZ not taken
    clear_mem();
    load(4'h0, 8'h09); load(4'h1, 8'h2A); load(4'h2, 8'h77); load(4'h3, 8'hE0);
    load(4'h4, 8'hF0); load(4'h9, 8'h03); load(4'hA, 8'h05);
    exp_q.push_back(8'hFE);
    p0 = pulses;
    run_prog(40, 0, cyc, pc0);
    check("sub_halt_cycles", cyc, 14);
    check("sub_acc", acc_dbg, 8'hFE);
    check("sub_carry", carry, 0);
    check("sub_zero", zero, 0);
    check("sub_pulses", pulses - p0, 1);

    // STA round trip, then restart from HALT
    clear_mem();
    load(4'h0, 8'h43); load(4'h1, 8'h3F); load(4'h2, 8'h0F); load(4'h3, 8'hE0);
    load(4'h4, 8'hF0);
    exp_q.push_back(8'h03);
    run_prog(40, 0, cyc, pc0);
    check("sta_halt_cycles", cyc, 13);
    check("sta_mem_f", dut.mem_q[15], 8'h03);
    check("sta_pc_at_halt", pc_dbg, 4'h5);
    load(4'hF, 8'h80);
    exp_q.push_back(8'h03);
    run_prog(40, 0, cyc, pc0);
    check("restart_pc0", pc0, 4'h0);
    check("restart_halt_cycles", cyc, 13);
    check("restart_mem_f", dut.mem_q[15], 8'h03);

    // prog_we while busy must be ignored
    exp_q.push_back(8'h03);
    run_prog(40, 1, cyc, pc0);
    check("busy_we_mem_c", dut.mem_q[12], 8'h80);
    check("busy_we_halted", halted, 1);

    // Reset in the middle of ADD, RAM intact, rerun
    clear_mem();
    load(4'h0, 8'h09); load(4'h1, 8'h1A); load(4'h2, 8'hE0); load(4'h3, 8'hF0);
    load(4'h9, 8'h05); load(4'hA, 8'h03);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    check("midadd_busy", busy, 1);
    do_reset(1);
    check("midrst_busy", busy, 0);
    check("midrst_acc", acc_dbg, 0);
    check("midrst_mem9", dut.mem_q[9], 8'h05);
    check("midrst_mema", dut.mem_q[10], 8'h03);
    exp_q.push_back(8'h08);
    run_prog(40, 0, cyc, pc0);
    check("rerun_halt_cycles", cyc, 12);

    // NOP-only program: PC must wrap F -> 0
    clear_mem();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wrapped = 1'b0;
    prev_pc = pc_dbg;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (prev_pc == 4'hF && pc_dbg == 4'h0) wrapped = 1'b1;
      prev_pc = pc_dbg;
    end
    check("nop_pc_wrap", wrapped, 1);
    check("nop_busy", busy, 1);
    do_reset(2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_core_param.md
Name: sap_core_param

Overview:
- Parametrised next-generation SAP core: program counter, MAR/IR, B register, ALU, accumulator and output register in one clocked block.
- Adds over the fixed 8-bit SAP-1 datapath:
  - a program-load port, with on-chip RAM of depth 2^ADDR_W;
  - a start/halt run control;
  - STA, immediate load, and carry/zero conditional jumps;
  - a carry flag and a valid-qualified output.
- Sits as the CPU top under the system bench; the bench loads a program, pulses start and monitors out_data/halted.

Parameters:
- DATA_W, 8, data/memory word width.
- ADDR_W, 4, address width; memory depth = 2^ADDR_W.
- OPC_W, 4, opcode width. Legal configurations require OPC_W >= 4 and DATA_W >= OPC_W+ADDR_W.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- prog_we  in  1  program-load write strobe
- prog_addr  in  ADDR_W  program-load address
- prog_data  in  DATA_W  program-load data
- start  in  1  begin execution from address 0
- busy  out  1  core executing (not IDLE/HALT)
- halted  out  1  HLT executed
- out_data  out  DATA_W  output register
- out_valid  out  1  one-cycle pulse when OUT executes
- acc_dbg  out  DATA_W  accumulator
- pc_dbg  out  ADDR_W  program counter
- zero  out  1  zero flag
- carry  out  1  carry flag

Behaviour:

Reset:
- The synchronous, active-low reset (reset=0 at a clk edge) forces state=IDLE.
- It clears PC, MAR, IR, B, ACC, out_data, zero, carry, out_valid, halted and busy to 0.
- RAM contents are not cleared.
- Reset mid-execution aborts the current instruction; no pending write completes.

Memory:
- Combinational read.
- Synchronous write from either the program-load port or STA.

Instruction word:
- Opcode = word[OPC_W+ADDR_W-1:ADDR_W]; operand = word[ADDR_W-1:0].
- Bits above OPC_W+ADDR_W are ignored.

Opcodes:
- 0 LDA: ACC=M[op]
- 1 ADD: ACC=ACC+M[op]
- 2 SUB: ACC=ACC-M[op]
- 3 STA: M[op]=ACC
- 4 LDI: ACC=zero-extended op
- 5 JMP: PC=op
- 6 JC: jump to op if carry=1
- 7 JZ: jump to op if zero=1
- 0xE OUT: out_data=ACC, out_valid=1 for one cycle
- 0xF HLT: stop
- All others: NOP

State machine:
- IDLE -> FETCH when start=1.
- At that edge PC=0, ACC=0, zero=0, carry=0, halted=0. start is also accepted from HALT.
- FETCH: IR<=M[PC], PC<=PC+1, wrapping from 2^ADDR_W-1 to 0.
- DECODE:
  - LDI, JMP, JC, JZ, OUT and NOP complete here, then return to FETCH.
  - HLT -> HALT.
  - LDA/ADD/SUB/STA: MAR<=op, then -> MEM.
- MEM:
  - LDA/ADD/SUB: B<=M[MAR], -> ALU.
  - STA: write M[MAR]=ACC, -> FETCH.
- ALU: ACC<=result, update flags, -> FETCH.
- HALT: stays in HALT until start or reset.

Instruction latency, counted from the FETCH edge:
- LDA/ADD/SUB: 4 cycles.
- STA: 3 cycles.
- All others: 2 cycles.

Arithmetic:
- ADD: (DATA_W+1)-bit sum; carry = MSB of the sum.
- SUB: ACC + ~B + 1; carry=1 means no borrow (ACC>=B).
- LDA and LDI: carry unchanged.
- zero = (new ACC==0); updated only by LDA, LDI, ADD and SUB.

Status outputs:
- busy=1 in FETCH, DECODE, MEM and ALU.
- halted=1 only in HALT.

Program-load port:
- prog_we is honoured only in IDLE or HALT; it is ignored while busy.
- prog_we and start on the same edge: the write lands and execution starts; the first FETCH sees the new data.
- start while busy is ignored.

Test Plan:
- Reset: hold reset=0 for 2 cycles after arbitrary activity -> busy=0, halted=0, acc_dbg=0, pc_dbg=0, out_data=0, out_valid=0, zero=0, carry=0.
- Add program: load M0=LDA 9 (0x09), M1=ADD A (0x1A), M2=OUT (0xE0), M3=HLT (0xF0), M9=0x05, MA=0x03, then pulse start -> out_data=0x08 with exactly one out_valid pulse; halted=1 exactly 12 cycles after start.
- Overflow and JC: M9=0xFF, MA=0x01; program LDA 9, ADD A, JC 6, LDI 1, OUT, HLT, with M6=OUT and M7=HLT -> acc=0x00, zero=1, carry=1; out_data=0x00; the LDI at M3 is never executed.
- SUB borrow and JZ not taken: M9=0x03, MA=0x05; program LDA 9, SUB A, JZ 7, OUT, HLT -> out_data=0xFE, carry=0, zero=0, one out_valid pulse.
- STA round trip: program LDI 3, STA F, LDA F, OUT, HLT -> MF=0x03, out_data=0x03. Restart from HALT with start -> same result, with PC beginning at 0.
- Robustness, three checks:
  - prog_we during busy leaves RAM unchanged.
  - reset=0 in the middle of an ADD -> IDLE, ACC=0, RAM intact; a rerun gives the identical out_data.
  - A program of NOPs with no HLT shows pc_dbg wrapping from 0xF to 0x0.
